// File: rtl/rob_retire_if.sv
// rtl/rob_retire_if.sv - rename/execute/free-list handshake bundle for the retirement buffer
interface rob_retire_if #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int ROB_BITS     = 5
);
  logic                alloc_valid;
  logic                alloc_ready;
  logic                alloc_old_valid [MAX_OPERANDS];
  logic [PRN_BITS-1:0] alloc_old_prn   [MAX_OPERANDS];
  logic [ROB_BITS-1:0] alloc_id;
  logic                complete_valid  [MAX_OPERANDS];
  logic [ROB_BITS-1:0] complete_id     [MAX_OPERANDS];
  logic                free_valid      [MAX_OPERANDS];
  logic [PRN_BITS-1:0] free_prns       [MAX_OPERANDS];
  logic                commit_valid;
  logic [ROB_BITS-1:0] commit_id;
  logic [ROB_BITS:0]   count;

  // Renamer / execution side
  modport master (
    output alloc_valid, alloc_old_valid, alloc_old_prn, complete_valid, complete_id,
    input  alloc_ready, alloc_id, free_valid, free_prns, commit_valid, commit_id, count
  );

  // Retirement buffer side
  modport slave (
    input  alloc_valid, alloc_old_valid, alloc_old_prn, complete_valid, complete_id,
    output alloc_ready, alloc_id, free_valid, free_prns, commit_valid, commit_id, count
  );
endinterface

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - in-order retirement buffer returning overwritten PRNs to the free list
module rob_retire #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int ROB_BITS     = 5
) (
  input  logic        clk,
  input  logic        rst,
  rob_retire_if.slave bus
);
  localparam int                  DEPTH     = 1 << ROB_BITS;
  localparam logic [ROB_BITS:0]   DEPTH_CNT = (ROB_BITS+1)'(DEPTH);
  localparam logic [ROB_BITS:0]   CNT_ONE   = (ROB_BITS+1)'(1);
  localparam logic [ROB_BITS-1:0] PTR_ONE   = ROB_BITS'(1);

  logic [DEPTH-1:0]    busy_q, done_q, busy_d, done_d;
  logic                old_valid_q [DEPTH][MAX_OPERANDS];
  logic [PRN_BITS-1:0] old_prn_q   [DEPTH][MAX_OPERANDS];
  logic [ROB_BITS-1:0] head_q, tail_q;
  logic [ROB_BITS:0]   count_q;
  logic                free_valid_q [MAX_OPERANDS];
  logic [PRN_BITS-1:0] free_prns_q  [MAX_OPERANDS];
  logic                commit_valid_q;
  logic [ROB_BITS-1:0] commit_id_q;
  logic                alloc_fire;
  logic                retire;

  // No retire bypass: a slot freed this edge is only visible through count next cycle
  assign bus.alloc_ready = (count_q < DEPTH_CNT);
  assign bus.alloc_id    = tail_q;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign retire          = busy_q[head_q] && done_q[head_q];

  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_id    = commit_id_q;
  assign bus.count        = count_q;

  for (genvar g = 0; g < MAX_OPERANDS; g++) begin : g_free_out
    assign bus.free_valid[g] = free_valid_q[g];
    assign bus.free_prns[g]  = free_prns_q[g];
  end

  // Slot flag updates; ordering makes retire override completion and allocation override both
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (bus.complete_valid[i] && busy_q[bus.complete_id[i]]) begin
        done_d[bus.complete_id[i]] = 1'b1;
      end
    end
    if (retire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
    end
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
    end
  end

  // Slot busy/done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      done_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Old-mapping payload, only meaningful while the slot is busy so it needs no reset
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        old_valid_q[tail_q][i] <= bus.alloc_old_valid[i];
        old_prn_q[tail_q][i]   <= bus.alloc_old_prn[i];
      end
    end
  end

  // Head and tail pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (retire)     head_q <= head_q + PTR_ONE;
      if (alloc_fire) tail_q <= tail_q + PTR_ONE;
    end
  end

  // Occupancy: unchanged when alloc and retire coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (alloc_fire && !retire) begin
      count_q <= count_q + CNT_ONE;
    end else if (retire && !alloc_fire) begin
      count_q <= count_q - CNT_ONE;
    end
  end

  // Retirement outputs: valids pulse for one cycle, payload holds between retirements
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        free_valid_q[i] <= 1'b0;
        free_prns_q[i]  <= '0;
      end
    end else begin
      commit_valid_q <= retire;
      if (retire) commit_id_q <= head_q;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        free_valid_q[i] <= retire && old_valid_q[head_q][i];
        if (retire) free_prns_q[i] <= old_prn_q[head_q][i];
      end
    end
  end
endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - self-checking bench for rob_retire
module tb_rob_retire;
  localparam int PB = 6;
  localparam int NO = 3;
  localparam int RB = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_retire_if #(.PRN_BITS(PB), .MAX_OPERANDS(NO), .ROB_BITS(RB)) bus ();
  rob_retire #(.PRN_BITS(PB), .MAX_OPERANDS(NO), .ROB_BITS(RB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: ordered list of in-flight instructions
  typedef struct packed {
    logic [4:0]  id;
    logic [2:0]  ov;
    logic [17:0] prns;
    logic        done;
  } ent_t;
  ent_t q[$];
  logic [2:0]  m_fv;
  logic [17:0] m_prns;
  logic        m_cv;
  logic [4:0]  m_cid;
  logic [4:0]  m_tail;

  logic        cur_av;
  logic [2:0]  cur_ov, cur_cv;
  logic [17:0] cur_prns;
  logic [14:0] cur_cids;

  typedef struct packed {
    logic        av;
    logic [2:0]  ov;
    logic [17:0] prns;
    logic [2:0]  cv;
    logic [14:0] cids;
    logic [2:0]  e_fv;
    logic [17:0] e_prns;
    logic        e_cv;
    logic [4:0]  e_cid;
    logic [5:0]  e_cnt;
  } vec_t;
  vec_t tab [15];

  function automatic logic [17:0] p3(input int a, input int b, input int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic logic [14:0] c3(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic vec_t mk(input logic av, input logic [2:0] ov, input logic [17:0] prns,
                              input logic [2:0] cv, input logic [14:0] cids, input logic [2:0] e_fv,
                              input logic [17:0] e_prns, input logic e_cv, input int e_cid, input int e_cnt);
    vec_t v;
    v.av = av; v.ov = ov; v.prns = prns; v.cv = cv; v.cids = cids;
    v.e_fv = e_fv; v.e_prns = e_prns; v.e_cv = e_cv; v.e_cid = 5'(e_cid); v.e_cnt = 6'(e_cnt);
    return v;
  endfunction

  function automatic logic [2:0] get_fv();
    logic [2:0] r;
    for (int l = 0; l < NO; l++) r[l] = bus.free_valid[l];
    return r;
  endfunction

  function automatic logic [17:0] get_prns();
    logic [17:0] r;
    for (int l = 0; l < NO; l++) r[l*6 +: 6] = bus.free_prns[l];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fv = '0; m_prns = '0; m_cv = 1'b0; m_cid = '0; m_tail = '0;
  endtask

  task automatic model_edge();
    bit   ret;
    int   sz;
    ent_t e;
    sz  = q.size();
    ret = (sz > 0) && q[0].done;
    for (int l = 0; l < NO; l++) begin
      if (cur_cv[l]) begin
        for (int j = 0; j < q.size(); j++) begin
          if (q[j].id == cur_cids[l*5 +: 5]) begin
            e = q[j]; e.done = 1'b1; q[j] = e;
          end
        end
      end
    end
    if (ret) begin
      m_fv = q[0].ov; m_prns = q[0].prns; m_cv = 1'b1; m_cid = q[0].id;
      q.delete(0);
    end else begin
      m_fv = '0; m_cv = 1'b0;
    end
    if (cur_av && sz < DEPTH) begin
      e.id = m_tail; e.ov = cur_ov; e.prns = cur_prns; e.done = 1'b0;
      q.push_back(e);
      m_tail = m_tail + 5'd1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},        32'(bus.count),        32'(q.size()));
    check({tag, ".alloc_ready"},  32'(bus.alloc_ready),  32'(q.size() < DEPTH));
    check({tag, ".alloc_id"},     32'(bus.alloc_id),     32'(m_tail));
    check({tag, ".free_valid"},   32'(get_fv()),         32'(m_fv));
    check({tag, ".free_prns"},    32'(get_prns()),       32'(m_prns));
    check({tag, ".commit_valid"}, 32'(bus.commit_valid), 32'(m_cv));
    check({tag, ".commit_id"},    32'(bus.commit_id),    32'(m_cid));
  endtask

  task automatic drive(input logic av, input logic [2:0] ov, input logic [17:0] prns,
                       input logic [2:0] cv, input logic [14:0] cids);
    cur_av = av; cur_ov = ov; cur_prns = prns; cur_cv = cv; cur_cids = cids;
    bus.alloc_valid = av;
    for (int l = 0; l < NO; l++) begin
      bus.alloc_old_valid[l] = ov[l];
      bus.alloc_old_prn[l]   = prns[l*6 +: 6];
      bus.complete_valid[l]  = cv[l];
      bus.complete_id[l]     = cids[l*5 +: 5];
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset mid-cycle, checked immediately and across one edge
  task automatic do_reset(input string tag);
    drive(1'b0, '0, '0, '0, '0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, '0, '0, '0);
    model_reset();
    #2 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed table: single instruction, then out-of-order completion with duplicates
    tab[0]  = mk(1, 3'b011, p3(5,7,9),   3'b000, c3(0,0,0), 3'b000, p3(0,0,0),   0, 0, 1);
    tab[1]  = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b000, p3(0,0,0),   0, 0, 1);
    tab[2]  = mk(0, 3'b000, p3(0,0,0),   3'b001, c3(0,0,0), 3'b000, p3(0,0,0),   0, 0, 1);
    tab[3]  = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b011, p3(5,7,9),   1, 0, 0);
    tab[4]  = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b000, p3(5,7,9),   0, 0, 0);
    tab[5]  = mk(1, 3'b001, p3(10,0,0),  3'b000, c3(0,0,0), 3'b000, p3(5,7,9),   0, 0, 1);
    tab[6]  = mk(1, 3'b001, p3(11,0,0),  3'b000, c3(0,0,0), 3'b000, p3(5,7,9),   0, 0, 2);
    tab[7]  = mk(1, 3'b001, p3(12,0,0),  3'b000, c3(0,0,0), 3'b000, p3(5,7,9),   0, 0, 3);
    tab[8]  = mk(0, 3'b000, p3(0,0,0),   3'b001, c3(3,0,0), 3'b000, p3(5,7,9),   0, 0, 3);
    tab[9]  = mk(0, 3'b000, p3(0,0,0),   3'b011, c3(2,2,0), 3'b000, p3(5,7,9),   0, 0, 3);
    tab[10] = mk(0, 3'b000, p3(0,0,0),   3'b011, c3(1,3,0), 3'b000, p3(5,7,9),   0, 0, 3);
    tab[11] = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b001, p3(10,0,0),  1, 1, 2);
    tab[12] = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b001, p3(11,0,0),  1, 2, 1);
    tab[13] = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b001, p3(12,0,0),  1, 3, 0);
    tab[14] = mk(0, 3'b000, p3(0,0,0),   3'b000, c3(0,0,0), 3'b000, p3(12,0,0),  0, 3, 0);
    for (int r = 0; r < 15; r++) begin
      drive(tab[r].av, tab[r].ov, tab[r].prns, tab[r].cv, tab[r].cids);
      step("tab_model");
      check($sformatf("tab%0d.free_valid", r),   32'(get_fv()),         32'(tab[r].e_fv));
      check($sformatf("tab%0d.free_prns", r),    32'(get_prns()),       32'(tab[r].e_prns));
      check($sformatf("tab%0d.commit_valid", r), 32'(bus.commit_valid), 32'(tab[r].e_cv));
      check($sformatf("tab%0d.commit_id", r),    32'(bus.commit_id),    32'(tab[r].e_cid));
      check($sformatf("tab%0d.count", r),        32'(bus.count),        32'(tab[r].e_cnt));
    end

    // Full boundary
    do_reset("rst_full");
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 3'b100, p3(0,0,i), '0, '0);
      step("fill");
    end
    check("full.count", 32'(bus.count), 32'd32);
    check("full.alloc_ready", 32'(bus.alloc_ready), 32'd0);
    drive(1'b1, 3'b111, p3(60,61,62), '0, '0);
    step("full_extra");
    check("full_extra.count", 32'(bus.count), 32'd32);
    check("full_extra.alloc_id", 32'(bus.alloc_id), 32'd0);
    drive(1'b0, '0, '0, 3'b100, c3(0,0,0));
    step("full_complete");
    check("full_complete.alloc_ready", 32'(bus.alloc_ready), 32'd0);
    drive(1'b0, '0, '0, '0, '0);
    step("full_retire");
    check("full_retire.alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("full_retire.commit_id", 32'(bus.commit_id), 32'd0);
    check("full_retire.free_prns2", 32'(bus.free_prns[2]), 32'd0);
    check("full_retire.alloc_id", 32'(bus.alloc_id), 32'd0);
    drive(1'b1, 3'b001, p3(33,0,0), '0, '0);
    step("full_refill");
    check("full_refill.count", 32'(bus.count), 32'd32);

    // Wrap with overlapping alloc and retire
    do_reset("rst_wrap");
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 3'b001, p3(i,0,0), (i > 0) ? 3'b001 : 3'b000, c3((i + 31) % 32, 0, 0));
      step("wrap");
      if (i >= 1) check("wrap.count", 32'(bus.count), 32'd2);
      if (i >= 2) begin
        check("wrap.commit_id", 32'(bus.commit_id), 32'((i - 2) % 32));
        check("wrap.free_prn0", 32'(bus.free_prns[0]), 32'(i - 2));
      end
    end

    // Reset while free_valid is high, then with done slots in flight
    do_reset("rst_busy_free");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b111, p3(i+1, i+2, i+3), '0, '0);
      step("mid_alloc");
    end
    drive(1'b0, '0, '0, 3'b011, c3(0,1,0));
    step("mid_complete");
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step("post_rst_idle");
      check("post_rst.free_valid", 32'(get_fv()), 32'd0);
    end
    check("post_rst.alloc_id", 32'(bus.alloc_id), 32'd0);
    drive(1'b1, 3'b001, p3(7,0,0), '0, '0);
    step("post_rst_alloc");
    check("post_rst_alloc.count", 32'(bus.count), 32'd1);

    // Randomized traffic: fill-heavy phase then drain-heavy phase
    for (int n = 0; n < 1200; n++) begin
      logic [2:0]  cv;
      logic [14:0] cids;
      logic [4:0]  cid;
      int aprob, cprob;
      aprob = (n < 600) ? 85 : 35;
      cprob = (n < 600) ? 15 : 50;
      for (int l = 0; l < NO; l++) begin
        cv[l] = ($urandom_range(0, 99) < cprob);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) cid = q[$urandom_range(0, q.size() - 1)].id;
        else cid = 5'($urandom);
        cids[l*5 +: 5] = cid;
      end
      drive($urandom_range(0, 99) < aprob, 3'($urandom), 18'($urandom), cv, cids);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rob_retire.md
# rob_retire

In-order retirement buffer that receives the overwritten register mappings produced by the renamer and returns those physical registers to the renamer's free list. It is a circular buffer, one slot per renamed instruction. Execution units mark slots done out of order, and the block retires the oldest slot once it is done. It sits between rename (upstream, producer of old mappings) and the renamer's `free_valid`/`free_prns` inputs (downstream).

## Interface
Parameters:
- `PRN_BITS`, 6, physical register number width
- `MAX_OPERANDS`, 3, old-mapping lanes per instruction; free lanes per retirement
- `ROB_BITS`, 5, slot index width; DEPTH = 1<<ROB_BITS (32)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `alloc_valid`  in  1  renamer presents a mapped instruction (renamer `mapping_valid`)
- `alloc_ready`  out  1  a slot is available; combinational, equals count < DEPTH
- `alloc_old_valid[MAX_OPERANDS]`  in  1  lane holds an overwritten PRN
- `alloc_old_prn[MAX_OPERANDS]`  in  PRN_BITS  overwritten PRN to free at retirement
- `alloc_id`  out  ROB_BITS  slot index that an accepted alloc receives; equals tail
- `complete_valid[MAX_OPERANDS]`  in  1  execution-done report
- `complete_id[MAX_OPERANDS]`  in  ROB_BITS  slot being reported done
- `free_valid[MAX_OPERANDS]`  out  1  registered; PRN returned to the free list this cycle
- `free_prns[MAX_OPERANDS]`  out  PRN_BITS  registered; PRN being freed
- `commit_valid`  out  1  registered; one-cycle pulse per retirement
- `commit_id`  out  ROB_BITS  registered; slot that retired
- `count`  out  ROB_BITS+1  registered occupancy, 0..DEPTH

## Operation
- Per-slot state: `busy`, `done`, and per lane `old_valid[]` and `old_prn[]`. Pointers `head` and `tail` are ROB_BITS wide and wrap modulo DEPTH naturally.
- **Allocation** fires when `alloc_valid && alloc_ready`.
  - Slot[tail] is written: busy=1, done=0, and the old lanes are copied.
  - tail increments.
  - An allocation with all `alloc_old_valid` at 0 still occupies a slot; it frees nothing at retirement.
  - `alloc_valid` while full is ignored and has no side effects.
- **Completion:**
  - For each lane i with `complete_valid[i]` set and slot[complete_id[i]].busy, set done=1.
  - A completion to a non-busy slot is ignored.
  - Duplicate completions, in the same cycle or later, are idempotent.
  - A completion that targets the slot being allocated in the same cycle is lost; allocation wins.
- **Retirement** happens at most once per cycle, when slot[head].busy && slot[head].done, using registered state.
  - On that edge: free_valid[i] <= slot.old_valid[i], free_prns[i] <= slot.old_prn[i], commit_valid <= 1, commit_id <= head.
  - Also on that edge: slot busy=0, done=0, and head increments.
  - On edges with no retirement: free_valid all 0 and commit_valid 0. free_prns and commit_id hold their previous values.
- **Occupancy:** count increments on alloc only, decrements on retire only, and is unchanged when both occur.
  - alloc_ready does not see a same-cycle retirement; there is no bypass.
- **Reset** (asynchronous, immediate, including mid-operation):
  - head=tail=0, count=0, all busy/done cleared.
  - free_valid all 0, free_prns all 0, commit_valid 0, commit_id 0.
  - Hence alloc_ready=1 and alloc_id=0.
  - Slots in flight are discarded and their PRNs are not freed.

## Timing
- Allocation is visible in count the cycle after the accepting edge.
- A completion presented in cycle c sets done at edge c. The earliest retire edge is c+1, and free_valid is high during cycle c+2 (2-cycle completion-to-free latency when the slot is at head).
- Back-to-back retirement: one slot per cycle while consecutive head slots are done.
- free_valid and commit_valid are single-cycle pulses and are never held.
- Full boundary: once count reaches DEPTH, alloc_ready is low from the next cycle. It goes high again the cycle after a retire edge.
- Empty boundary: a done check on a non-busy head never retires.

## Test plan
- **Reset:** assert rst asynchronously → immediately alloc_ready=1, alloc_id=0, count=0, free_valid={0,0,0}, commit_valid=0.
- **Single instruction:** alloc old_valid={1,1,0}, old_prn={5,7,9} at cycle 1 (alloc_id=0); complete_id[0]=0 at cycle 3 → cycle 5: free_valid={1,1,0}, free_prns={5,7,x}, commit_valid=1, commit_id=0 for exactly one cycle; count=0 afterwards.
- **Out of order:** alloc ids 0,1,2 with old_prn 10,11,12 on lane 0; complete 2, then 1, then 0 in successive cycles → frees 10,11,12 on three consecutive cycles, in that order.
- **Full:** 32 allocs with no completions → count=32, alloc_ready=0. A 33rd alloc_valid changes nothing. Complete id 0 → retire; alloc_ready=1 the cycle after; next alloc_id=0.
- **Wrap and simultaneous events:** 40 alloc+complete pairs with alloc and retire overlapping → ids wrap 31→0, count stays constant during overlap, and frees emerge in allocation order.
- **Reset mid-operation:** 5 busy slots, 2 done, assert rst → no free_valid pulse for any of them. After release, a fresh alloc gets id 0.
